// File: rtl/seq_cla_subtractor.sv
// Multi-cycle two's-complement subtractor: diff = a - b - bin.
// One 4-bit carry-look-ahead slice of a + ~b + carry is evaluated per clock,
// LSB slice first, with valid/ready handshakes on both sides.
module seq_cla_subtractor #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic             ovf,
    output logic             zero
);

    localparam int N  = WIDTH / 4;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [N-1:0][3:0] a_q, a_d;
    logic [N-1:0][3:0] nb_q, nb_d;      // subtrahend is stored already inverted
    logic [N-1:0][3:0] diff_q, diff_d;
    logic              carry_q, carry_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              in_ready_q, in_ready_d;
    logic              out_valid_q, out_valid_d;
    logic              bout_q, bout_d;
    logic              ovf_q, ovf_d;
    logic              zero_q, zero_d;

    logic [3:0] a_s, nb_s, g, p, sum4;
    logic [4:0] c;
    logic       last_slice;

    // Current slice: 4-bit carry-look-ahead of a + ~b + carry.
    always_comb begin
        a_s  = a_q[cnt_q];
        nb_s = nb_q[cnt_q];
        g    = a_s & nb_s;
        p    = a_s ^ nb_s;
        c[0] = carry_q;
        c[1] = g[0] | (p[0] & c[0]);
        c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c[0]);
        c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
             | (p[2] & p[1] & p[0] & c[0]);
        c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
             | (p[3] & p[2] & p[1] & g[0])
             | (p[3] & p[2] & p[1] & p[0] & c[0]);
        sum4 = p ^ c[3:0];
        last_slice = (cnt_q == CW'(N - 1));
    end

    // Next-state logic for the IDLE -> CALC -> DONE sequencer and datapath.
    always_comb begin
        state_d     = state_q;
        a_d         = a_q;
        nb_d        = nb_q;
        diff_d      = diff_q;
        carry_d     = carry_q;
        cnt_d       = cnt_q;
        in_ready_d  = in_ready_q;
        out_valid_d = out_valid_q;
        bout_d      = bout_q;
        ovf_d       = ovf_q;
        zero_d      = zero_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d        = a;
                    nb_d       = ~b;
                    carry_d    = ~bin;
                    cnt_d      = '0;
                    in_ready_d = 1'b0;
                    state_d    = CALC;
                end
            end
            CALC: begin
                diff_d[cnt_q] = sum4;
                carry_d       = c[4];
                cnt_d         = cnt_q + 1'b1;
                if (last_slice) begin
                    // a and b signs differ exactly when a and ~b signs match
                    bout_d      = ~c[4];
                    ovf_d       = (a_q[N-1][3] == nb_q[N-1][3]) & (sum4[3] != a_q[N-1][3]);
                    zero_d      = ~|diff_d;
                    out_valid_d = 1'b1;
                    state_d     = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    in_ready_d  = 1'b1;
                    state_d     = IDLE;
                end
            end
            default: begin
                out_valid_d = 1'b0;
                in_ready_d  = 1'b1;
                state_d     = IDLE;
            end
        endcase
    end

    // State and output registers; reset aborts any operation in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            a_q         <= '0;
            nb_q        <= '0;
            diff_q      <= '0;
            carry_q     <= 1'b0;
            cnt_q       <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            bout_q      <= 1'b0;
            ovf_q       <= 1'b0;
            zero_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            a_q         <= a_d;
            nb_q        <= nb_d;
            diff_q      <= diff_d;
            carry_q     <= carry_d;
            cnt_q       <= cnt_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            bout_q      <= bout_d;
            ovf_q       <= ovf_d;
            zero_q      <= zero_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign diff      = diff_q;
    assign bout      = bout_q;
    assign ovf       = ovf_q;
    assign zero      = zero_q;

endmodule

// File: tb/tb_seq_cla_subtractor.sv
// Bench for seq_cla_subtractor (WIDTH=16): directed vector table, seeded
// random vectors against an arithmetic model, backpressure and mid-op reset.
module tb_seq_cla_subtractor;

    localparam int W = 16;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         bin = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] diff;
    logic         bout, ovf, zero;

    int checks = 0;
    int failures = 0;

    seq_cla_subtractor #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .bin(bin),
        .out_valid(out_valid), .out_ready(out_ready),
        .diff(diff), .bout(bout), .ovf(ovf), .zero(zero)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         bin;
        logic [W-1:0] diff;
        logic         bout;
        logic         ovf;
        logic         zero;
    } vec_t;

    vec_t vecs[10];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    // Present operands, wait for acceptance, then count edges to out_valid.
    task automatic start_op(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic tbin,
                            output int lat);
        int wait_cnt;
        wait_cnt = 0;
        while (!in_ready && wait_cnt < 20) begin
            @(posedge clk); #1;
            wait_cnt++;
        end
        check("in_ready_before_op", 32'(in_ready), 32'd1);
        a = ta; b = tb; bin = tbin; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        a = 16'hDEAD; b = 16'hBEEF; bin = ~tbin;   // operands may change after accept
        lat = 0;
        while (!out_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic check_result(input string tag, input vec_t v, input int lat);
        $display("op %s a=%h b=%h bin=%0d -> diff=%h bout=%0d ovf=%0d zero=%0d lat=%0d",
                 tag, v.a, v.b, v.bin, diff, bout, ovf, zero, lat);
        check({tag, "_latency"}, 32'(lat), 32'd4);
        check({tag, "_diff"}, 32'(diff), 32'(v.diff));
        check({tag, "_bout"}, 32'(bout), 32'(v.bout));
        check({tag, "_ovf"}, 32'(ovf), 32'(v.ovf));
        check({tag, "_zero"}, 32'(zero), 32'(v.zero));
    endtask

    task automatic handshake(input string tag);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check({tag, "_out_valid_after_hs"}, 32'(out_valid), 32'd0);
        check({tag, "_in_ready_after_hs"}, 32'(in_ready), 32'd1);
    endtask

    function automatic vec_t model(input logic [W-1:0] ma, input logic [W-1:0] mb, input logic mbin);
        vec_t v;
        logic [W:0] r;
        r = {1'b0, ma} - {1'b0, mb} - {{W{1'b0}}, mbin};
        v.a = ma; v.b = mb; v.bin = mbin;
        v.diff = r[W-1:0];
        v.bout = r[W];
        v.ovf  = (ma[W-1] != mb[W-1]) && (r[W-1] != ma[W-1]);
        v.zero = (r[W-1:0] == '0);
        return v;
    endfunction

    initial begin
        int lat;
        vec_t v;
        logic [W-1:0] held;

        vecs[0] = '{16'h1234, 16'h0234, 1'b0, 16'h1000, 1'b0, 1'b0, 1'b0};
        vecs[1] = '{16'h0000, 16'h0001, 1'b0, 16'hFFFF, 1'b1, 1'b0, 1'b0};
        vecs[2] = '{16'h0005, 16'h0004, 1'b1, 16'h0000, 1'b0, 1'b0, 1'b1};
        vecs[3] = '{16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b0, 1'b1, 1'b0};
        vecs[4] = '{16'h7FFF, 16'hFFFF, 1'b0, 16'h8000, 1'b1, 1'b1, 1'b0};
        vecs[5] = '{16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 1'b0, 1'b0};
        vecs[6] = '{16'h0000, 16'h0000, 1'b1, 16'hFFFF, 1'b1, 1'b0, 1'b0};
        vecs[7] = '{16'hABCD, 16'h1234, 1'b0, 16'h9999, 1'b0, 1'b0, 1'b0};
        vecs[8] = '{16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1};
        vecs[9] = '{16'h1000, 16'h0001, 1'b0, 16'h0FFF, 1'b0, 1'b0, 1'b0};

        // Reset state
        #12;
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_diff", 32'(diff), 32'd0);
        check("rst_flags", 32'({bout, ovf, zero}), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Directed table
        for (int i = 0; i < 10; i++) begin
            start_op(vecs[i].a, vecs[i].b, vecs[i].bin, lat);
            check_result($sformatf("vec%0d", i), vecs[i], lat);
            handshake($sformatf("vec%0d", i));
        end

        // Backpressure: result held for 10 cycles, in_valid pulses ignored
        start_op(16'h1234, 16'h0234, 1'b0, lat);
        check_result("bp", vecs[0], lat);
        held = diff;
        for (int i = 0; i < 10; i++) begin
            in_valid = i[0];
            a = 16'h5555; b = 16'h1111;
            @(posedge clk); #1;
            check("bp_hold_out_valid", 32'(out_valid), 32'd1);
            check("bp_hold_in_ready", 32'(in_ready), 32'd0);
            check("bp_hold_diff", 32'(diff), 32'(held));
            check("bp_hold_flags", 32'({bout, ovf, zero}), 32'd0);
        end
        in_valid = 1'b0;
        handshake("bp");
        // A stray accepted pulse would make the IDLE state busy; confirm it stays idle
        @(posedge clk); #1;
        check("bp_idle_stays_ready", 32'(in_ready), 32'd1);

        // Mid-operation reset during slice 2
        a = 16'h4321; b = 16'h1111; bin = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        check("midrst_in_ready", 32'(in_ready), 32'd1);
        check("midrst_diff", 32'(diff), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            check("midrst_no_result", 32'(out_valid), 32'd0);
        end
        v = model(16'h8765, 16'h0766, 1'b1);
        start_op(v.a, v.b, v.bin, lat);
        check_result("post_rst", v, lat);
        handshake("post_rst");

        // Seeded random vectors against the arithmetic model
        for (int i = 0; i < 200; i++) begin
            v = model(W'($urandom), W'($urandom), 1'($urandom_range(0, 1)));
            start_op(v.a, v.b, v.bin, lat);
            check_result($sformatf("rnd%0d", i), v, lat);
            handshake($sformatf("rnd%0d", i));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
